mem_responder: RTL and testbench

- Word-organised RAM that acts as the responder (slave) for the generated-core memory bus: addr/size/valid/write/wdata out of the core, rdata/ready back in.
- Serves the exact handshake the c2hdl cores issue:
  - valid is pulsed and re-issued while ready is low;
  - the core captures rdata and advances on the cycle where ready is high;
  - the core expects ready low before its next access.
- Sits beside a core (e.g. levenshtein) as its stack/data memory in simulation and FPGA builds.

---
 rtl/mem_responder_if.sv | 22 ++
 rtl/mem_responder.sv | 171 +++++++++++++++++
 tb/tb_mem_responder.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Memory bus between a generated core (master) and a word RAM responder (slave).
// The core drives the request and the responder returns rdata/ready/err.
interface mem_responder_if;
  logic [31:0] addr;
  logic [2:0]  size;
  logic        valid;
  logic        write;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  modport master (
    output addr, size, valid, write, wdata,
    input  rdata, ready, err
  );

  modport slave (
    input  addr, size, valid, write, wdata,
    output rdata, ready, err
  );
endinterface

// File: rtl/mem_responder.sv
// Word-organised RAM responder for the generated-core memory bus: accepts one
// request, waits LATENCY cycles, then holds ready until the core releases valid.
module mem_responder #(
  parameter int unsigned ADDR_BITS = 8,
  parameter logic [31:0] BASE      = 32'h0,
  parameter int unsigned LATENCY   = 0
) (
  input  logic           clk,
  input  logic           rstb,
  mem_responder_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_BITS;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [2:0]  size_reg;
  logic        write_reg;
  logic        ready_reg;
  logic        err_reg;
  logic        rdata_ok_reg;

  logic        fire;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [2:0]  acc_size;
  logic        acc_write;
  logic [31:0] offset;
  logic [1:0]  lane_off;
  logic [ADDR_BITS-1:0] idx;
  logic        in_range;
  logic        misaligned;
  logic        acc_err;
  logic        ram_en;
  logic [3:0]  lane_we;
  logic [31:0] lane_wd;
  logic [31:0] ram_q;

  // With no wait cycles the RAM is accessed on the acceptance edge, so the
  // live bus request is used; otherwise the latched request is used.
  always_comb begin
    acc_addr  = addr_reg;
    acc_wdata = wdata_reg;
    acc_size  = size_reg;
    acc_write = write_reg;
    if (state_reg == IDLE) begin
      acc_addr  = bus.addr;
      acc_wdata = bus.wdata;
      acc_size  = bus.size;
      acc_write = bus.write;
    end
  end

  assign fire = (LATENCY == 0) ? ((state_reg == IDLE) && bus.valid)
                               : ((state_reg == WAIT) && (cnt_reg == 4'd0));

  // BASE is word-aligned, so the low offset bits equal addr[1:0].
  assign offset     = acc_addr - BASE;
  assign lane_off   = offset[1:0];
  assign idx        = offset[ADDR_BITS+1:2];
  assign in_range   = ((offset >> (ADDR_BITS + 2)) == 32'h0);
  assign misaligned = (acc_size > 3'd2) ||
                      ((acc_size == 3'd1) && lane_off[0]) ||
                      ((acc_size == 3'd2) && (lane_off != 2'd0));
  assign acc_err    = misaligned || !in_range;
  assign ram_en     = fire && !acc_err && rstb;

  always_comb begin
    lane_we = 4'b0000;
    lane_wd = acc_wdata;
    if (acc_write) begin
      case (acc_size)
        3'd0: begin
          lane_we = 4'b0001 << lane_off;
          lane_wd = {4{acc_wdata[7:0]}};
        end
        3'd1: begin
          lane_we = 4'b0011 << lane_off;
          lane_wd = {2{acc_wdata[15:0]}};
        end
        default: lane_we = 4'b1111;
      endcase
    end
  end

  // One write-first byte RAM per lane so rdata shows the post-write word.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [0:DEPTH-1];
      logic [7:0] lane_q_reg;

      always_ff @(posedge clk) begin
        if (ram_en) begin
          if (lane_we[gi]) begin
            lane_mem[idx] <= lane_wd[8*gi +: 8];
            lane_q_reg    <= lane_wd[8*gi +: 8];
          end else begin
            lane_q_reg    <= lane_mem[idx];
          end
        end
      end

      assign ram_q[8*gi +: 8] = lane_q_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      addr_reg     <= 32'h0;
      wdata_reg    <= 32'h0;
      size_reg     <= 3'd0;
      write_reg    <= 1'b0;
      ready_reg    <= 1'b0;
      err_reg      <= 1'b0;
      rdata_ok_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.valid) begin
            addr_reg  <= bus.addr;
            wdata_reg <= bus.wdata;
            size_reg  <= bus.size;
            write_reg <= bus.write;
            if (LATENCY == 0) begin
              state_reg <= RESP;
              ready_reg <= 1'b1;
            end else begin
              state_reg <= WAIT;
              cnt_reg   <= 4'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (cnt_reg == 4'd0) begin
            state_reg <= RESP;
            ready_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        RESP: begin
          if (!bus.valid) begin
            state_reg <= IDLE;
            ready_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          ready_reg <= 1'b0;
        end
      endcase

      if (fire) begin
        rdata_ok_reg <= !acc_err;
        if (acc_err) begin
          err_reg <= 1'b1;
        end
      end
    end
  end

  assign bus.ready = ready_reg;
  assign bus.err   = err_reg;
  assign bus.rdata = rdata_ok_reg ? ram_q : 32'h0;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a zero-latency instance and a LATENCY=3 instance
// with a nonzero BASE, checked against a behavioural word-memory model.
module tb_mem_responder;
  localparam logic [31:0] BASE0 = 32'h0;
  localparam logic [31:0] BASE1 = 32'h1000;

  logic clk  = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  mem_responder_if bus0 ();
  mem_responder_if bus1 ();

  mem_responder #(.ADDR_BITS(8), .BASE(BASE0), .LATENCY(0)) dut0 (
    .clk (clk),
    .rstb(rstb),
    .bus (bus0)
  );

  mem_responder #(.ADDR_BITS(8), .BASE(BASE1), .LATENCY(3)) dut1 (
    .clk (clk),
    .rstb(rstb),
    .bus (bus1)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb_q [$];
  logic [31:0] mdl0 [int];
  logic [31:0] mdl1 [int];
  bit          model_err [2];
  int          checks   = 0;
  int          failures = 0;

  function automatic logic [31:0] model_get(input int sel, input int key);
    if (sel == 0) return mdl0.exists(key) ? mdl0[key] : 32'h0;
    return mdl1.exists(key) ? mdl1[key] : 32'h0;
  endfunction

  task automatic model_set(input int sel, input int key, input logic [31:0] word);
    if (sel == 0) mdl0[key] = word;
    else          mdl1[key] = word;
  endtask

  function automatic bit model_bad(input logic [31:0] a, input logic [2:0] s,
                                   input logic [31:0] base);
    logic [31:0] off;
    off = a - base;
    if (s > 3'd2) return 1'b1;
    if (s == 3'd1 && a[0]) return 1'b1;
    if (s == 3'd2 && a[1:0] != 2'd0) return 1'b1;
    if (off >= 32'd1024) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [31:0] a,
                       input logic [2:0] s, input logic w, input logic [31:0] d);
    if (sel == 0) begin
      bus0.valid = v; bus0.addr = a; bus0.size = s; bus0.write = w; bus0.wdata = d;
    end else begin
      bus1.valid = v; bus1.addr = a; bus1.size = s; bus1.write = w; bus1.wdata = d;
    end
  endtask

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? bus0.ready : bus1.ready;
  endfunction

  function automatic logic get_err(input int sel);
    return (sel == 0) ? bus0.err : bus1.err;
  endfunction

  function automatic logic [31:0] get_rdata(input int sel);
    return (sel == 0) ? bus0.rdata : bus1.rdata;
  endfunction

  // Push the model's expectation, run one handshake, pop and compare on ready.
  task automatic do_xact(input int sel, input logic [31:0] a, input logic [2:0] s,
                         input logic w, input logic [31:0] d, input string name,
                         output logic [31:0] obs);
    exp_t        e;
    logic [31:0] base;
    logic [31:0] word;
    int          key;
    int          lat;
    bit          got;
    base = (sel == 0) ? BASE0 : BASE1;
    if (model_bad(a, s, base)) begin
      e.rdata = 32'h0;
      model_err[sel] = 1'b1;
    end else begin
      key  = int'((a - base) >> 2);
      word = model_get(sel, key);
      if (w) begin
        for (int i = 0; i < (1 << s); i++) begin
          word[(int'(a[1:0]) + i) * 8 +: 8] = d[i * 8 +: 8];
        end
        model_set(sel, key, word);
      end
      e.rdata = word;
    end
    e.err = model_err[sel];
    e.lat = (sel == 0) ? 1 : 4;
    sb_q.push_back(e);

    @(posedge clk); #1;
    drive(sel, 1'b1, a, s, w, d);
    got = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (get_ready(sel) === 1'b1) begin
        got = 1'b1;
        lat = c;
        break;
      end
    end
    e = sb_q.pop_front();
    checks++;
    if (!got) begin
      $display("FAIL %s ready_timeout observed=0 expected=1 within 20 cycles", name);
      failures++;
      drive(sel, 1'b0, 32'h0, 3'd0, 1'b0, 32'h0);
      obs = 32'h0;
      return;
    end
    if (lat !== e.lat) begin
      $display("FAIL %s latency observed=%0d expected=%0d", name, lat, e.lat);
      failures++;
    end
    obs = get_rdata(sel);
    checks++;
    if (obs !== e.rdata) begin
      $display("FAIL %s rdata observed=%08h expected=%08h", name, obs, e.rdata);
      failures++;
    end
    checks++;
    if (get_err(sel) !== e.err) begin
      $display("FAIL %s err observed=%0b expected=%0b", name, get_err(sel), e.err);
      failures++;
    end
    drive(sel, 1'b0, 32'h0, 3'd0, 1'b0, 32'h0);
    @(posedge clk); #1;
    checks++;
    if (get_ready(sel) !== 1'b0) begin
      $display("FAIL %s ready_release observed=%0b expected=0", name, get_ready(sel));
      failures++;
    end
    $display("xact %-16s dut%0d addr=%08h size=%0d write=%0b rdata=%08h lat=%0d",
             name, sel, a, s, w, obs, lat);
  endtask

  task automatic test_reset;
    drive(0, 1'b0, 32'h0, 3'd0, 1'b0, 32'h0);
    drive(1, 1'b0, 32'h0, 3'd0, 1'b0, 32'h0);
    rstb = 1'b0;
    #12;
    for (int sel = 0; sel < 2; sel++) begin
      checks++;
      if (get_ready(sel) !== 1'b0) begin
        $display("FAIL reset_ready dut%0d observed=%0b expected=0", sel, get_ready(sel));
        failures++;
      end
      checks++;
      if (get_rdata(sel) !== 32'h0) begin
        $display("FAIL reset_rdata dut%0d observed=%08h expected=0", sel, get_rdata(sel));
        failures++;
      end
      checks++;
      if (get_err(sel) !== 1'b0) begin
        $display("FAIL reset_err dut%0d observed=%0b expected=0", sel, get_err(sel));
        failures++;
      end
    end
    @(posedge clk); #1;
    rstb = 1'b1;
  endtask

  task automatic test_word;
    logic [31:0] obs;
    do_xact(0, 32'h24, 3'd2, 1'b1, 32'hDEADBEEF, "sw_0x24", obs);
    do_xact(0, 32'h24, 3'd2, 1'b0, 32'h0, "lw_0x24", obs);
  endtask

  task automatic test_byte;
    logic [31:0] obs;
    logic [7:0]  lbu;
    do_xact(0, 32'h25, 3'd0, 1'b1, 32'h000000AA, "sb_0x25", obs);
    do_xact(0, 32'h24, 3'd2, 1'b0, 32'h0, "lw_after_sb", obs);
    do_xact(0, 32'h26, 3'd0, 1'b0, 32'h0, "lbu_0x26", obs);
    lbu = 8'(obs >> 16);
    checks++;
    if (lbu !== 8'hAD) begin
      $display("FAIL lbu_shift observed=%02h expected=ad", lbu);
      failures++;
    end
  endtask

  task automatic test_half;
    logic [31:0] obs;
    do_xact(0, 32'h26, 3'd1, 1'b1, 32'h00001234, "sh_0x26", obs);
    do_xact(0, 32'h24, 3'd2, 1'b0, 32'h0, "lw_after_sh", obs);
    do_xact(0, 32'h25, 3'd1, 1'b1, 32'h0000FFFF, "sh_misaligned", obs);
    do_xact(0, 32'h24, 3'd2, 1'b0, 32'h0, "lw_after_bad_sh", obs);
    do_xact(0, 32'h24, 3'd3, 1'b0, 32'h0, "illegal_size", obs);
  endtask

  task automatic test_range;
    logic [31:0] obs;
    do_xact(0, 32'h3FC, 3'd2, 1'b1, 32'h0A0B0C0D, "sw_last_word", obs);
    do_xact(0, 32'h3FC, 3'd2, 1'b0, 32'h0, "lw_last_word", obs);
    do_xact(0, 32'h400, 3'd2, 1'b0, 32'h0, "lw_out_of_range", obs);
    do_xact(1, 32'h0FFC, 3'd2, 1'b0, 32'h0, "lw_below_base", obs);
  endtask

  task automatic test_latency_toggle;
    logic [31:0] obs;
    exp_t        e;
    int          lat;
    int          extra;
    bit          got;
    do_xact(1, BASE1 + 32'h80, 3'd2, 1'b1, 32'h5555AAAA, "sw_l3_0x80", obs);
    do_xact(1, BASE1 + 32'h84, 3'd2, 1'b1, 32'h0BADF00D, "sw_l3_0x84", obs);
    e.rdata = model_get(1, 32);
    e.err   = model_err[1];
    e.lat   = 4;
    sb_q.push_back(e);
    @(posedge clk); #1;
    drive(1, 1'b1, BASE1 + 32'h80, 3'd2, 1'b0, 32'h0);
    got = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (bus1.ready === 1'b1) begin
        got = 1'b1;
        lat = c;
        break;
      end
      if (c == 1) drive(1, 1'b0, BASE1 + 32'h80, 3'd2, 1'b0, 32'h0);
      if (c == 2) drive(1, 1'b1, BASE1 + 32'h84, 3'd2, 1'b0, 32'h0);
      if (c == 3) drive(1, 1'b0, BASE1 + 32'h84, 3'd2, 1'b0, 32'h0);
    end
    e = sb_q.pop_front();
    checks++;
    if (!got || lat !== e.lat) begin
      $display("FAIL toggle_latency observed=%0d expected=%0d", lat, e.lat);
      failures++;
    end
    checks++;
    if (bus1.rdata !== e.rdata) begin
      $display("FAIL toggle_rdata observed=%08h expected=%08h", bus1.rdata, e.rdata);
      failures++;
    end
    drive(1, 1'b0, 32'h0, 3'd0, 1'b0, 32'h0);
    @(posedge clk); #1;
    checks++;
    if (bus1.ready !== 1'b0) begin
      $display("FAIL toggle_release observed=%0b expected=0", bus1.ready);
      failures++;
    end
    extra = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus1.ready === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin
      $display("FAIL toggle_single_accept extra_ready_cycles observed=%0d expected=0", extra);
      failures++;
    end
    $display("xact %-16s dut1 addr=%08h rdata=%08h lat=%0d", "lw_l3_toggle",
             BASE1 + 32'h80, bus1.rdata, lat);
  endtask

  task automatic test_reset_in_wait;
    logic [31:0] obs;
    do_xact(1, BASE1 + 32'h40, 3'd2, 1'b1, 32'hCAFEF00D, "sw_pre_0x40", obs);
    @(posedge clk); #1;
    drive(1, 1'b1, BASE1 + 32'h40, 3'd2, 1'b1, 32'h11111111);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstb = 1'b0;
    #1;
    checks++;
    if (bus1.ready !== 1'b0) begin
      $display("FAIL reset_wait_ready observed=%0b expected=0", bus1.ready);
      failures++;
    end
    checks++;
    if (bus1.err !== 1'b0 || bus0.err !== 1'b0) begin
      $display("FAIL reset_wait_err observed=%0b/%0b expected=0/0", bus0.err, bus1.err);
      failures++;
    end
    drive(1, 1'b0, 32'h0, 3'd0, 1'b0, 32'h0);
    model_err[0] = 1'b0;
    model_err[1] = 1'b0;
    @(posedge clk); #1;
    rstb = 1'b1;
    do_xact(1, BASE1 + 32'h40, 3'd2, 1'b0, 32'h0, "lw_after_reset", obs);
    do_xact(0, 32'h24, 3'd2, 1'b0, 32'h0, "lw0_after_reset", obs);
  endtask

  initial begin
    model_err[0] = 1'b0;
    model_err[1] = 1'b0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_range();
    test_latency_toggle();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end
endmodule
